// File: rtl/cpu_pkg.sv
// Shared CPU definitions: IR field positions, opcodes, widths and fetch-state encoding.
// S_HALT exists only when IFU_HALT_DETECT_EN is defined.
package cpu_pkg;

   localparam int ADDR_W_DEF = 11;
   localparam int DATA_W_DEF = 32;

   // IR field bit positions
   localparam int OPER_MSB     = 31;
   localparam int OPER_LSB     = 27;
   localparam int RDST_MSB     = 26;
   localparam int RDST_LSB     = 22;
   localparam int RSRC1_MSB    = 21;
   localparam int RSRC1_LSB    = 17;
   localparam int IMM_MODE_BIT = 16;
   localparam int RSRC2_MSB    = 15;
   localparam int RSRC2_LSB    = 11;
   localparam int ISRC_MSB     = 15;
   localparam int ISRC_LSB     = 0;

   localparam logic [4:0] OP_MOVSGPR = 5'd0;
   localparam logic [4:0] OP_MOV     = 5'd1;
   localparam logic [4:0] OP_ADD     = 5'd2;
   localparam logic [4:0] OP_SUB     = 5'd3;
   localparam logic [4:0] OP_MUL     = 5'd4;
   localparam logic [4:0] OP_ROR     = 5'd5;
   localparam logic [4:0] OP_RAND    = 5'd6;
   localparam logic [4:0] OP_RXOR    = 5'd7;
   localparam logic [4:0] OP_RXNOR   = 5'd8;
   localparam logic [4:0] OP_RNAND   = 5'd9;
   localparam logic [4:0] OP_RNOR    = 5'd10;
   localparam logic [4:0] OP_RNOT    = 5'd11;
   localparam logic [4:0] OP_HALT    = 5'b11111;

`ifdef IFU_HALT_DETECT_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} fetch_state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1} fetch_state_t;
`endif

   function automatic logic [4:0] oper_type(input logic [31:0] ir);
      return ir[OPER_MSB:OPER_LSB];
   endfunction

endpackage

// File: rtl/ifu_queue.sv
// Two-entry FIFO of {pc, instr} words for the fetch unit, with flush.
// Head reads as zero while empty so the IR outputs idle at zero.
module ifu_queue #(
   parameter int W = 43
) (
   input  logic         clk,
   input  logic         sys_rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic [1:0]   count,
   output logic         full,
   output logic         empty
);

   logic [W-1:0] mem [2];
   logic         rd_ptr;
   logic         wr_ptr;

   always_ff @(posedge clk) begin
      if (sys_rst || flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign empty = (count == 2'd0);
   assign full  = (count == 2'd2);
   assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, 1-cycle-latency BRAM reads, 2-entry IR queue, jump redirect.
// Optional HALT-opcode stop is enabled by defining IFU_HALT_DETECT_EN.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int QDEPTH = 2
) (
   input  logic              clk,
   input  logic              sys_rst,
   output logic              imem_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_dout,
   input  logic              jmp_valid,
   input  logic [ADDR_W-1:0] jmp_addr,
   output logic              ir_valid,
   input  logic              ir_ready,
   output logic [DATA_W-1:0] ir_out,
   output logic [ADDR_W-1:0] ir_pc,
   output logic              fetch_busy
);

   fetch_state_t               state, state_nx;
   logic [ADDR_W-1:0]          pc, inflight_pc;
   logic                       inflight;
   logic                       issue, push, pop;
   logic [1:0]                 q_count;
   logic                       q_full, q_empty;
   logic [ADDR_W+DATA_W-1:0]   q_head;
   logic [2:0]                 occ;

   assign occ = {1'b0, q_count} + {2'b00, inflight};
   assign pop = !q_empty && ir_ready && !jmp_valid;

   // A read returning while halted belongs to a word after HALT and is dropped
`ifdef IFU_HALT_DETECT_EN
   assign push = inflight && !jmp_valid && (state != S_HALT);
`else
   assign push = inflight && !jmp_valid;
`endif

   always_comb begin
      state_nx = state;
      issue    = 1'b0;
      case (state)
         S_IDLE: state_nx = S_RUN;
         S_RUN: begin
            issue = !jmp_valid && (pop || (!q_full && (occ < 3'(QDEPTH))));
`ifdef IFU_HALT_DETECT_EN
            if (push && oper_type(imem_dout) == OP_HALT) state_nx = S_HALT;
`endif
         end
`ifdef IFU_HALT_DETECT_EN
         S_HALT: state_nx = S_HALT;
`endif
         default: state_nx = S_IDLE;
      endcase
      if (jmp_valid) state_nx = S_RUN;
   end

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state       <= S_IDLE;
         pc          <= '0;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         state    <= state_nx;
         inflight <= issue;
         if (issue) begin
            inflight_pc <= pc;
            pc          <= pc + ADDR_W'(1);
         end
         if (jmp_valid) pc <= jmp_addr;
      end
   end

   ifu_queue #(.W(ADDR_W + DATA_W)) u_queue (
      .clk     (clk),
      .sys_rst (sys_rst),
      .push    (push),
      .pop     (pop),
      .flush   (jmp_valid),
      .din     ({inflight_pc, imem_dout}),
      .head    (q_head),
      .count   (q_count),
      .full    (q_full),
      .empty   (q_empty)
   );

   assign imem_en    = issue;
   assign imem_addr  = pc;
   assign ir_valid   = !q_empty;
   assign ir_out     = q_head[DATA_W-1:0];
   assign ir_pc      = q_head[DATA_W +: ADDR_W];
   assign fetch_busy = (q_count != 2'd0) | inflight;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural 1-cycle BRAM (word[n] = n + 0x100).
// Cycle c0 is the S_IDLE cycle after reset release; HALT checks follow IFU_HALT_DETECT_EN.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        sys_rst;
   logic        imem_en;
   logic [10:0] imem_addr;
   logic [31:0] imem_dout;
   logic        jmp_valid;
   logic [10:0] jmp_addr;
   logic        ir_valid;
   logic        ir_ready;
   logic [31:0] ir_out;
   logic [10:0] ir_pc;
   logic        fetch_busy;

   logic [31:0] mem [2048];
   int ncmp = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk        (clk),
      .sys_rst    (sys_rst),
      .imem_en    (imem_en),
      .imem_addr  (imem_addr),
      .imem_dout  (imem_dout),
      .jmp_valid  (jmp_valid),
      .jmp_addr   (jmp_addr),
      .ir_valid   (ir_valid),
      .ir_ready   (ir_ready),
      .ir_out     (ir_out),
      .ir_pc      (ir_pc),
      .fetch_busy (fetch_busy)
   );

   always @(posedge clk) if (imem_en) imem_dout <= mem[imem_addr];

   // the queue must never see a push while full without a matching pop
   always @(negedge clk) begin
      if (!sys_rst) begin
         ncmp++;
         assert (!(dut.push && dut.q_full && !dut.pop)) else begin
            nerr++;
            $error("FAIL push_on_full: push=%0b full=%0b pop=%0b, required no push while full",
                   dut.push, dut.q_full, dut.pop);
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 32'h100 + i;
      sys_rst = 1'b1; jmp_valid = 1'b0; jmp_addr = '0; ir_ready = 1'b1;
      nxt(); nxt();
      sys_rst = 1'b0; #1;
      // c0: idle cycle, everything zero
      chk("rst_valid", ir_valid, 0);
      chk("rst_out", ir_out, 0);
      chk("rst_pc", ir_pc, 0);
      chk("rst_busy", fetch_busy, 0);
      chk("idle_en", imem_en, 0);
      nxt(); #1; // c1
      chk("c1_en", imem_en, 1);
      chk("c1_addr", imem_addr, 0);
      chk("c1_busy", fetch_busy, 0);
      nxt(); #1; // c2
      chk("c2_valid", ir_valid, 0);
      chk("c2_addr", imem_addr, 1);
      chk("c2_busy", fetch_busy, 1);
      for (int c = 3; c <= 4; c++) begin
         nxt(); #1;
         chk("stream_valid", ir_valid, 1);
         chk("stream_pc", ir_pc, c - 3);
         chk("stream_out", ir_out, 32'h100 + c - 3);
      end
      // stall c5..c10
      nxt(); ir_ready = 1'b0; #1;
      chk("stall_pc", ir_pc, 2);
      chk("stall_en_c5", imem_en, 0);
      for (int c = 6; c <= 10; c++) begin
         nxt(); #1;
         chk("stall_hold_pc", ir_pc, 2);
         chk("stall_hold_out", ir_out, 32'h102);
         chk("stall_en", imem_en, 0);
         chk("stall_busy", fetch_busy, 1);
      end
      nxt(); ir_ready = 1'b1; #1; // c11
      chk("resume_pc", ir_pc, 2);
      chk("resume_en", imem_en, 1);
      chk("resume_addr", imem_addr, 4);
      for (int c = 12; c <= 13; c++) begin
         nxt(); #1;
         chk("resume_seq", ir_pc, c - 9);
      end
      // redirect with a read in flight (c14)
      nxt(); jmp_valid = 1'b1; jmp_addr = 11'h040; #1;
      chk("jmp_head", ir_pc, 5);
      chk("jmp_no_issue", imem_en, 0);
      nxt(); jmp_valid = 1'b0; #1;
      chk("jmp_flush_valid", ir_valid, 0);
      chk("jmp_issue_addr", imem_addr, 11'h040);
      chk("jmp_issue_en", imem_en, 1);
      chk("jmp_busy", fetch_busy, 0);
      nxt(); #1;
      chk("jmp_squash_valid", ir_valid, 0);
      chk("jmp_addr2", imem_addr, 11'h041);
      nxt(); #1;
      chk("jmp_pc0", ir_pc, 11'h040);
      chk("jmp_out0", ir_out, 32'h140);
      nxt(); #1;
      chk("jmp_pc1", ir_pc, 11'h041);
      chk("jmp_out1", ir_out, 32'h141);
      // fill the queue, then redirect to near the top of memory
      nxt(); ir_ready = 1'b0;
      nxt(); nxt();
      jmp_valid = 1'b1; jmp_addr = 11'h7FE; ir_ready = 1'b1; #1;
      chk("full_head", ir_pc, 11'h042);
      chk("full_jmp_en", imem_en, 0);
      nxt(); jmp_valid = 1'b0; #1;
      chk("full_flush", ir_valid, 0);
      chk("wrap_issue", imem_addr, 11'h7FE);
      nxt(); nxt(); #1;
      chk("wrap_pc_7fe", ir_pc, 11'h7FE);
      chk("wrap_out_7fe", ir_out, 32'h8FE);
      nxt(); #1;
      chk("wrap_pc_7ff", ir_pc, 11'h7FF);
      chk("wrap_out_7ff", ir_out, 32'h8FF);
      nxt(); #1;
      chk("wrap_pc_000", ir_pc, 11'h000);
      chk("wrap_out_000", ir_out, 32'h100);
      nxt(); #1;
      chk("wrap_pc_001", ir_pc, 11'h001);
      // mid-stream reset with a redirect that must be ignored; plant HALT at 3
      nxt(); sys_rst = 1'b1; jmp_valid = 1'b1; jmp_addr = 11'h123; mem[3] = 32'hF800_0003;
      nxt(); sys_rst = 1'b0; jmp_valid = 1'b0; #1;
      chk("mrst_valid", ir_valid, 0);
      chk("mrst_out", ir_out, 0);
      chk("mrst_pc", ir_pc, 0);
      chk("mrst_busy", fetch_busy, 0);
      chk("mrst_en", imem_en, 0);
      nxt(); #1;
      chk("mrst_issue_en", imem_en, 1);
      chk("mrst_issue_addr", imem_addr, 0);
      chk("mrst_valid1", ir_valid, 0);
      nxt(); #1;
      chk("mrst_valid2", ir_valid, 0);
      for (int p = 0; p <= 2; p++) begin
         nxt(); #1;
         chk("mrst_seq_pc", ir_pc, p);
         chk("mrst_seq_out", ir_out, 32'h100 + p);
      end
      nxt(); #1;
      chk("halt_word_pc", ir_pc, 3);
      chk("halt_word_out", ir_out, 32'hF800_0003);
      nxt(); #1;
`ifdef IFU_HALT_DETECT_EN
      chk("halt_stop_valid", ir_valid, 0);
      chk("halt_stop_busy", fetch_busy, 0);
      chk("halt_stop_en", imem_en, 0);
      nxt(); #1;
      chk("halt_idle_valid", ir_valid, 0);
      chk("halt_idle_en", imem_en, 0);
`else
      chk("nohalt_pc4", ir_pc, 4);
      chk("nohalt_out4", ir_out, 32'h104);
      nxt(); #1;
      chk("nohalt_pc5", ir_pc, 5);
`endif
      nxt(); jmp_valid = 1'b1; jmp_addr = 11'h000;
      nxt(); jmp_valid = 1'b0; #1;
      chk("restart_valid", ir_valid, 0);
      chk("restart_en", imem_en, 1);
      chk("restart_addr", imem_addr, 0);
      nxt(); nxt(); #1;
      chk("restart_pc0", ir_pc, 0);
      chk("restart_out0", ir_out, 32'h100);
      nxt(); #1;
      chk("restart_pc1", ir_pc, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
